// File: rtl/axil_csr_pkg.sv
// Shared types, response codes and byte-merge helper for the AXI4-Lite CSR bank.
// Optional round-robin read/write arbitration is enabled by defining AXIL_CSR_RR_ARB_EN.
package axil_csr_pkg;

  typedef enum logic [1:0] {
    ACC_RW   = 2'b00,
    ACC_RO   = 2'b01,
    ACC_WO   = 2'b10,
    ACC_NONE = 2'b11
  } access_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WR_RESP,
    RD_RESP
  } state_t;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       strb);
    return strb ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/axil_csr_regs.sv
// Register storage for the CSR bank: strobe merge, write pulses, access checks and read mux.
module axil_csr_regs
  import axil_csr_pkg::*;
#(
  parameter int                          DATA_W     = 32,
  parameter int                          NUM_REGS   = 8,
  parameter int                          IDX_W      = 4,
  parameter logic [2*NUM_REGS-1:0]       REG_ACCESS = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]  REG_RST    = '0
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [DATA_W/8-1:0]          wr_strb,
  output logic                         wr_ok,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_ok,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  logic [NUM_REGS*DATA_W-1:0] reg_d;
  logic [NUM_REGS-1:0]        pulse_d, pulse_q;

  function automatic access_t acc_of(input int idx);
    return access_t'(REG_ACCESS[2*idx +: 2]);
  endfunction

  // Only RW/WO registers are writable; a zero strobe still counts as a commit.
  always_comb begin
    reg_d   = reg_q;
    pulse_d = '0;
    wr_ok   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i) && (acc_of(i) == ACC_RW || acc_of(i) == ACC_WO)) begin
        wr_ok = 1'b1;
        if (wr_en) begin
          pulse_d[i] = 1'b1;
          for (int b = 0; b < DATA_W/8; b++) begin
            reg_d[i*DATA_W + 8*b +: 8] = byte_merge(reg_q[i*DATA_W + 8*b +: 8],
                                                    wr_data[8*b +: 8], wr_strb[b]);
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        if (acc_of(i) == ACC_RW) begin
          rd_data = reg_q[i*DATA_W +: DATA_W];
          rd_ok   = 1'b1;
        end else if (acc_of(i) == ACC_RO) begin
          rd_data = hw_status[i*DATA_W +: DATA_W];
          rd_ok   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      reg_q   <= REG_RST;
      pulse_q <= '0;
    end else begin
      reg_q   <= reg_d;
      pulse_q <= pulse_d;
    end
  end

  assign wr_pulse = pulse_q;

endmodule

// File: rtl/axil_csr_bank.sv
// AXI4-Lite CSR bank top: channel capture, read/write arbitration and response FSM.
// Define AXIL_CSR_RR_ARB_EN for round-robin arbitration; default is fixed write priority.
module axil_csr_bank
  import axil_csr_pkg::*;
#(
  parameter int                          DATA_W     = 32,
  parameter int                          ADDR_W     = 6,
  parameter int                          NUM_REGS   = 8,
  parameter logic [2*NUM_REGS-1:0]       REG_ACCESS = {NUM_REGS{2'b00}},
  parameter logic [NUM_REGS*DATA_W-1:0]  REG_RST    = '0
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF;

  state_t              state_q, state_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic [IDX_W-1:0]    aw_idx_q, aw_idx_d, ar_idx_q, ar_idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic                wr_ready, grant_wr, grant_rd, wr_ok, rd_ok;
  logic [DATA_W-1:0]   rd_data;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^{awaddr, araddr};

`ifdef AXIL_CSR_RR_ARB_EN
  logic last_grant_q, last_grant_d;

  // last_grant = 0 means the next contended slot goes to the write.
  always_comb begin
    wr_ready     = aw_held_q & w_held_q;
    grant_wr     = (state_q == IDLE) & wr_ready & (!ar_held_q | !last_grant_q);
    grant_rd     = (state_q == IDLE) & ar_held_q & !grant_wr;
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) && wr_ready && ar_held_q) last_grant_d = ~last_grant_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) last_grant_q <= 1'b0;
    else         last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    wr_ready = aw_held_q & w_held_q;
    grant_wr = (state_q == IDLE) & wr_ready;
    grant_rd = (state_q == IDLE) & ar_held_q & !wr_ready;
  end
`endif

  axil_csr_regs #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .REG_ACCESS(REG_ACCESS),
    .REG_RST   (REG_RST)
  ) u_regs (
    .clk      (clk),
    .arst_n   (arst_n),
    .wr_en    (grant_wr),
    .wr_idx   (aw_idx_q),
    .wr_data  (wdata_q),
    .wr_strb  (wstrb_q),
    .wr_ok    (wr_ok),
    .rd_idx   (ar_idx_q),
    .rd_data  (rd_data),
    .rd_ok    (rd_ok),
    .hw_status(hw_status),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  // Held flags stay set until the response handshake, which keeps each channel's ready low.
  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ar_held_d = ar_held_q;
    ar_idx_d  = ar_idx_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    if (awvalid && !aw_held_q) begin
      aw_held_d = 1'b1;
      aw_idx_d  = awaddr[ADDR_W-1:OFF];
    end
    if (wvalid && !w_held_q) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    if (arvalid && !ar_held_q) begin
      ar_held_d = 1'b1;
      ar_idx_d  = araddr[ADDR_W-1:OFF];
    end

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          bvalid_d = 1'b1;
          bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
          state_d  = WR_RESP;
        end else if (grant_rd) begin
          rvalid_d = 1'b1;
          rdata_d  = rd_data;
          rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
          state_d  = RD_RESP;
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          ar_held_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ar_held_q <= 1'b0;
      ar_idx_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ar_held_q <= ar_held_d;
      ar_idx_q  <= ar_idx_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign awready = !aw_held_q;
  assign wready  = !w_held_q;
  assign arready = !ar_held_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axil_csr_bank.sv
// Directed self-checking bench for axil_csr_bank; register map: 0,1 RW, 2 RO, 3 WO, 4 NONE, 5-7 RW.
module tb_axil_csr_bank;

  localparam int               DATA_W = 32;
  localparam int               ADDR_W = 6;
  localparam int               NREGS  = 8;
  localparam logic [15:0]      TB_ACCESS = 16'h0390;
  localparam logic [255:0]     TB_RST = {192'h0, 32'h0000_1234, 32'h0};

  logic                 clk = 1'b0;
  logic                 arst_n = 1'b0;
  logic [ADDR_W-1:0]    awaddr = '0, araddr = '0;
  logic                 awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic                 bready = 1'b0, rready = 1'b0;
  logic [DATA_W-1:0]    wdata = '0;
  logic [3:0]           wstrb = '0;
  logic                 awready, wready, arready, bvalid, rvalid;
  logic [1:0]           bresp, rresp;
  logic [DATA_W-1:0]    rdata;
  logic [NREGS*DATA_W-1:0] hw_status = '0;
  logic [NREGS*DATA_W-1:0] reg_q;
  logic [NREGS-1:0]     wr_pulse;

  int nChecks = 0;
  int nFails  = 0;

  logic [1:0]  resp;
  logic [7:0]  pulse;
  logic [31:0] rd;

  axil_csr_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NREGS),
    .REG_ACCESS(TB_ACCESS), .REG_RST(TB_RST)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .hw_status(hw_status), .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  // Global time bound so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the selected request channels for exactly one cycle; called #1 after a rising edge.
  task automatic applyStimulus(input logic doAw, input logic doW, input logic doAr,
                               input logic [ADDR_W-1:0] wAddr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [ADDR_W-1:0] rAddr);
    awvalid = doAw; awaddr = wAddr;
    wvalid  = doW;  wdata  = data; wstrb = strb;
    arvalid = doAr; araddr = rAddr;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  task automatic waitWriteResp(output logic [1:0] r, output logic [7:0] p);
    for (int i = 0; i < 20 && !bvalid; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("bvalid_seen", bvalid, 1'b1);
    r = bresp;
    p = wr_pulse;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic waitReadResp(output logic [31:0] d, output logic [1:0] r);
    for (int i = 0; i < 20 && !rvalid; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("rvalid_seen", rvalid, 1'b1);
    d = rdata;
    r = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    hw_status[31:0]   = 32'h0BAD_F00D;
    hw_status[95:64]  = 32'hCAFE_0001;
    hw_status[127:96] = 32'hFFFF_FFFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_readies", {awready, wready, arready}, 3'b111);
    checkOutput("rst_valids", {bvalid, rvalid}, 2'b00);
    checkOutput("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    checkOutput("rst_reg_q", reg_q, TB_RST);
    checkOutput("rst_pulse", wr_pulse, 8'h00);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Full write then read of RW reg 0
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h00, 32'hDEAD_BEEF, 4'hF, 6'h00);
    waitWriteResp(resp, pulse);
    checkOutput("wr0_bresp", resp, 2'b00);
    checkOutput("wr0_pulse", pulse, 8'h01);
    checkOutput("wr0_pulse_gone", wr_pulse, 8'h00);
    checkOutput("wr0_reg", reg_q[31:0], 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00, 32'h0, 4'h0, 6'h00);
    waitReadResp(rd, resp);
    checkOutput("rd0_data", rd, 32'hDEAD_BEEF);
    checkOutput("rd0_rresp", resp, 2'b00);

    // Partial strobe merge
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h00, 32'h1122_3344, 4'h5, 6'h00);
    waitWriteResp(resp, pulse);
    checkOutput("strb5_reg", reg_q[31:0], 32'hDE22_BE44);

    // Same merge with W arriving two cycles ahead of AW
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h00, 32'hDEAD_BEEF, 4'hF, 6'h00);
    waitWriteResp(resp, pulse);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 32'h1122_3344, 4'h5, 6'h00);
    checkOutput("w_first_wready_low", wready, 1'b0);
    @(posedge clk); #1;
    checkOutput("w_first_no_resp", bvalid, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0, 6'h00);
    waitWriteResp(resp, pulse);
    checkOutput("w_first_bresp", resp, 2'b00);
    checkOutput("w_first_pulse", pulse, 8'h01);
    checkOutput("w_first_reg", reg_q[31:0], 32'hDE22_BE44);

    // Zero strobe still pulses and keeps the reset value
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h04, 32'hFFFF_FFFF, 4'h0, 6'h00);
    waitWriteResp(resp, pulse);
    checkOutput("strb0_bresp", resp, 2'b00);
    checkOutput("strb0_pulse", pulse, 8'h02);
    checkOutput("strb0_reg", reg_q[63:32], 32'h0000_1234);

    // RO register: write rejected, read returns hardware status
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h08, 32'h1234_5678, 4'hF, 6'h00);
    waitWriteResp(resp, pulse);
    checkOutput("ro_wr_bresp", resp, 2'b10);
    checkOutput("ro_wr_pulse", pulse, 8'h00);
    checkOutput("ro_wr_reg", reg_q[95:64], 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00, 32'h0, 4'h0, 6'h08);
    waitReadResp(rd, resp);
    checkOutput("ro_rd_data", rd, 32'hCAFE_0001);
    checkOutput("ro_rd_rresp", resp, 2'b00);

    // WO register: write stored, read blocked
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h0C, 32'hA5A5_A5A5, 4'hF, 6'h00);
    waitWriteResp(resp, pulse);
    checkOutput("wo_wr_bresp", resp, 2'b00);
    checkOutput("wo_wr_pulse", pulse, 8'h08);
    checkOutput("wo_wr_reg", reg_q[127:96], 32'hA5A5_A5A5);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00, 32'h0, 4'h0, 6'h0C);
    waitReadResp(rd, resp);
    checkOutput("wo_rd", {rd, resp}, {32'h0, 2'b10});

    // NONE register and out-of-range index
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00, 32'h0, 4'h0, 6'h10);
    waitReadResp(rd, resp);
    checkOutput("none_rd", {rd, resp}, {32'h0, 2'b10});
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h20, 32'h5555_5555, 4'hF, 6'h00);
    waitWriteResp(resp, pulse);
    checkOutput("oor_wr", {resp, pulse}, {2'b10, 8'h00});
    checkOutput("oor_wr_regs", reg_q, {96'h0, 32'hA5A5_A5A5, 32'h0, 32'h0000_1234, 32'hDE22_BE44});
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h00, 32'h0, 4'h0, 6'h20);
    waitReadResp(rd, resp);
    checkOutput("oor_rd", {rd, resp}, {32'h0, 2'b10});

    // First contended pair: write always wins
    applyStimulus(1'b1, 1'b1, 1'b1, 6'h14, 32'h0102_0304, 4'hF, 6'h14);
    for (int i = 0; i < 20 && !(bvalid || rvalid); i++) begin
      @(posedge clk); #1;
    end
    checkOutput("cont1_order", {bvalid, rvalid}, 2'b10);
    waitWriteResp(resp, pulse);
    checkOutput("cont1_wr", {resp, pulse}, {2'b00, 8'h20});
    waitReadResp(rd, resp);
    checkOutput("cont1_rd", {rd, resp}, {32'h0102_0304, 2'b00});

    // Second contended pair: read first under round-robin, write first otherwise
    applyStimulus(1'b1, 1'b1, 1'b1, 6'h18, 32'h0000_0055, 4'hF, 6'h18);
    for (int i = 0; i < 20 && !(bvalid || rvalid); i++) begin
      @(posedge clk); #1;
    end
`ifdef AXIL_CSR_RR_ARB_EN
    checkOutput("cont2_order", {bvalid, rvalid}, 2'b01);
    waitReadResp(rd, resp);
    checkOutput("cont2_rd", {rd, resp}, {32'h0, 2'b00});
    waitWriteResp(resp, pulse);
    checkOutput("cont2_wr", {resp, pulse}, {2'b00, 8'h40});
`else
    checkOutput("cont2_order", {bvalid, rvalid}, 2'b10);
    waitWriteResp(resp, pulse);
    checkOutput("cont2_wr", {resp, pulse}, {2'b00, 8'h40});
    waitReadResp(rd, resp);
    checkOutput("cont2_rd", {rd, resp}, {32'h0000_0055, 2'b00});
`endif

    // Back-pressured write response, then reset mid-response
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h1C, 32'h0000_0077, 4'hF, 6'h00);
    for (int i = 0; i < 20 && !bvalid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_b", {bvalid, bresp}, {1'b1, 2'b00});
      @(posedge clk); #1;
    end
    checkOutput("stall_awready", awready, 1'b0);
    checkOutput("stall_reg7", reg_q[255:224], 32'h0000_0077);
    arst_n = 1'b0;
    #2;
    checkOutput("midrst_valids", {bvalid, rvalid}, 2'b00);
    checkOutput("midrst_readies", {awready, wready, arready}, 3'b111);
    checkOutput("midrst_reg_q", reg_q, TB_RST);
    checkOutput("midrst_pulse", wr_pulse, 8'h00);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("post_rst_idle", {bvalid, rvalid, awready}, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/axil_csr_bank.md
Name: axil_csr_bank

Overview:
- AXI4-Lite slave with an internal bank of NUM_REGS parametrised control/status registers.
- Each register has its own access policy: RW, RO, WO or NONE.
- RO registers are live hardware status inputs; RW/WO registers are stored and exported to the fabric.
- AW and W channels are decoupled. Reads and writes are arbitrated onto one execution path. Illegal or out-of-range accesses return SLVERR.

Parameters:
- DATA_W, 32, data width; multiple of 8. Localparam STRB_W = DATA_W/8.
- ADDR_W, 6, byte-address width. Word index = addr[ADDR_W-1:$clog2(STRB_W)].
- NUM_REGS, 8, register count; must be <= 2^(ADDR_W-$clog2(STRB_W)).
- REG_ACCESS, {NUM_REGS{2'b00}}, 2 bits per register: 00 RW, 01 RO, 10 WO, 11 NONE.
- REG_RST, '0, NUM_REGS*DATA_W flattened reset values for stored registers.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- awaddr  in  ADDR_W  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_W  write data
- wstrb  in  STRB_W  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- hw_status  in  NUM_REGS*DATA_W  RO register values; slice i belongs to register i
- reg_q  out  NUM_REGS*DATA_W  stored RW/WO register values
- wr_pulse  out  NUM_REGS  one-cycle pulse on a successful write commit to register i

Behaviour:
- Reset is asynchronous, active-low.
  - awready, wready and arready reset to 1.
  - bvalid and rvalid reset to 0; bresp, rresp and rdata reset to 0.
  - reg_q resets to REG_RST; wr_pulse resets to 0.
  - The FSM resets to IDLE and all held flags clear.
- Capture:
  - An AW handshake latches the address and sets aw_held; awready = !aw_held.
  - A W handshake latches data and strobes and sets w_held; wready = !w_held.
  - An AR handshake latches the address and sets ar_held; arready = !ar_held.
  - AW and W may arrive in any order or in the same cycle.
- FSM states: IDLE, WR_RESP, RD_RESP.
- IDLE transitions:
  - Write ready (aw_held & w_held) and ar_held clear: commit the write, go to WR_RESP.
  - ar_held set and write not ready: perform the read, go to RD_RESP.
  - Both ready at once: write wins by default (see Optional Feature).
- Write commit, in the IDLE cycle:
  - The target index must be < NUM_REGS and its access must be RW or WO.
  - New value per byte: byte b takes wdata when wstrb[b]=1, otherwise keeps its old value.
  - wr_pulse[i] asserts for one cycle, including when wstrb = 0, which leaves the value unchanged.
  - bvalid=1 from the next cycle. bresp = 00, or 10 (SLVERR) for out-of-range, RO or NONE targets; the register is then untouched and no pulse fires.
- WR_RESP: hold bvalid/bresp until bready. On the handshake clear bvalid, aw_held and w_held, and return to IDLE.
- Read, in the IDLE cycle:
  - rdata is registered from reg_q (RW), hw_status (RO), or 0 (WO/NONE/out-of-range).
  - rresp = 00, or 10 for WO/NONE/out-of-range.
  - rvalid=1 next cycle.
- RD_RESP: hold rvalid/rdata/rresp stable until rready. On the handshake clear rvalid and ar_held, and return to IDLE.
- Latency: write from both-held to bvalid is 1 cycle; read from ar_held to rvalid is 1 cycle.
- Only one transaction executes at a time. A new AW, W or AR may be captured while the other channel's response is pending.
- Reset mid-transaction aborts it: responses drop and held requests are discarded.

Optional Feature:
- Macro AXIL_CSR_RR_ARB_EN.
- Defined: simultaneous read/write contention is resolved round-robin. A 1-bit last_grant flips after each contended grant; reset state favours write first.
- Undefined: fixed write priority. A read waits until no write is ready.

Decomposition:
- Package axil_csr_pkg:
  - access_t enum (ACC_RW, ACC_RO, ACC_WO, ACC_NONE)
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - state_t enum
  - function byte_merge(old, new, strb)
- Sub-module axil_csr_regs holds storage, strobe merge, wr_pulse and read mux. The top keeps channel capture, arbitration and FSM.

Test Plan:
- Write to reg 0 (RW), awaddr 0x00, wdata 0xDEADBEEF, wstrb 0xF -> bresp 00, reg_q[0]=0xDEADBEEF, wr_pulse[0] one cycle. Then read 0x00 -> rdata 0xDEADBEEF, rresp 00.
- Reg 0 = 0xDEADBEEF; write 0x11223344 with wstrb 0x5 -> reg_q[0]=0xDE22BE44. Same test with W two cycles before AW gives an identical result.
- Reg 2 RO with hw_status slice 0xCAFE0001: write 0x08 -> bresp 10, no pulse. Read 0x08 -> rdata 0xCAFE0001, rresp 00.
- Read WO reg -> rdata 0, rresp 10. Access index NUM_REGS (0x20) -> SLVERR on both write and read.
- AW, W and AR all valid in the same cycle -> write response before read data. With AXIL_CSR_RR_ARB_EN, a second contended pair is served read first.
- bready held low for 5 cycles -> bvalid and bresp stable. Assert arst_n low mid-response -> bvalid=0, readies=1, reg_q=REG_RST.
